// File: rtl/stereo_pkg.sv
// -----------------------------------------------------------------------------
// stereo_pkg
// Shared definitions for the stereo matrix encoder:
//   DATA_SIZE   default sample width (two's-complement signed samples)
//   sample_t    one sample
//   sat_narrow  clamps a DATA_SIZE+1 bit signed value into sample_t range
// -----------------------------------------------------------------------------
package stereo_pkg;

   localparam int DATA_SIZE = 32;

   typedef logic [DATA_SIZE-1:0] sample_t;

   localparam sample_t SAMPLE_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
   localparam sample_t SAMPLE_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

   // A DATA_SIZE+1 bit value fits in DATA_SIZE bits exactly when its two top
   // bits agree; otherwise the top bit tells which rail to clamp to.
   function automatic sample_t sat_narrow(input logic signed [DATA_SIZE:0] value);
      sample_t result;
      if (value[DATA_SIZE] != value[DATA_SIZE-1]) begin
         if (value[DATA_SIZE] == 1'b1) begin
            result = SAMPLE_MIN;
         end else begin
            result = SAMPLE_MAX;
         end
      end else begin
         result = value[DATA_SIZE-1:0];
      end
      return result;
   endfunction

endpackage

// File: rtl/stream_hold_reg.sv
// -----------------------------------------------------------------------------
// stream_hold_reg
// One-entry holding register feeding a downstream FIFO write port.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   load          capture load_data (overrides a simultaneous write-out)
//   load_data     sample to hold
//   full          downstream FIFO full
//   wr_en         write strobe: a sample is held and downstream has room
//   dout          held sample, stable while an entry is pending
//   ready         may load this cycle: empty, or the held sample leaves now
// -----------------------------------------------------------------------------
module stream_hold_reg
   import stereo_pkg::*;
(
   input  logic    clock,
   input  logic    reset,
   input  logic    load,
   input  sample_t load_data,
   input  logic    full,
   output logic    wr_en,
   output sample_t dout,
   output logic    ready
);

   logic    pend_r;
   sample_t data_r;

   // The reset term keeps a sample held at the moment of a mid-run reset
   // from being written out during the reset cycle itself.
   assign wr_en = pend_r & ~full & ~reset;
   assign ready = ~pend_r | wr_en;
   assign dout  = data_r;

   // Pending flag and data register; a load wins over a same-cycle write-out
   always_ff @(posedge clock) begin
      if (reset) begin
         pend_r <= 1'b0;
         data_r <= {DATA_SIZE{1'b0}};
      end else if (load) begin
         pend_r <= 1'b1;
         data_r <= load_data;
      end else if (wr_en) begin
         pend_r <= 1'b0;
      end else begin
         pend_r <= pend_r;
      end
   end

endmodule

// File: rtl/stereo_matrix_enc.sv
// -----------------------------------------------------------------------------
// stereo_matrix_enc
// Joins the left and right show-ahead sample FIFOs and forks each pair into an
// L+R (lpr) and an L-R (lmr) output stream with independent backpressure.
//   clock, reset              rising-edge clock, synchronous active-high reset
//   left_dout/empty/rd_en     left source FIFO head, empty flag, pop
//   right_dout/empty/rd_en    right source FIFO head, empty flag, pop
//   lpr_din/wr_en/full        L+R output FIFO write port
//   lmr_din/wr_en/full        L-R output FIFO write port
// Build option: define STEREO_MATRIX_SAT_EN to saturate sum/difference to the
// sample range; otherwise results wrap modulo 2^DATA_SIZE.
// -----------------------------------------------------------------------------
module stereo_matrix_enc
   import stereo_pkg::*;
(
   input  logic    clock,
   input  logic    reset,
   input  sample_t left_dout,
   input  logic    left_empty,
   output logic    left_rd_en,
   input  sample_t right_dout,
   input  logic    right_empty,
   output logic    right_rd_en,
   output sample_t lpr_din,
   output logic    lpr_wr_en,
   input  logic    lpr_full,
   output sample_t lmr_din,
   output logic    lmr_wr_en,
   input  logic    lmr_full
);

   logic    started_r;
   logic    lpr_ready_s;
   logic    lmr_ready_s;
   logic    pop_s;
   sample_t lpr_val_s;
   sample_t lmr_val_s;

`ifdef STEREO_MATRIX_SAT_EN
   logic [DATA_SIZE:0] sum_s;
   logic [DATA_SIZE:0] diff_s;

   assign sum_s     = {left_dout[DATA_SIZE-1], left_dout} + {right_dout[DATA_SIZE-1], right_dout};
   assign diff_s    = {left_dout[DATA_SIZE-1], left_dout} - {right_dout[DATA_SIZE-1], right_dout};
   assign lpr_val_s = sat_narrow(sum_s);
   assign lmr_val_s = sat_narrow(diff_s);
`else
   // Keeping only the low DATA_SIZE bits of the widened result is the plain
   // modular sum/difference, so the extra bit is never formed here.
   assign lpr_val_s = left_dout + right_dout;
   assign lmr_val_s = left_dout - right_dout;
`endif

   // Hold off popping until one full cycle after reset has been released
   always_ff @(posedge clock) begin
      if (reset) begin
         started_r <= 1'b0;
      end else begin
         started_r <= 1'b1;
      end
   end

   // A pair is taken only when both sides have data and both branches can
   // accept; both source FIFOs are always popped together.
   assign pop_s       = started_r & ~reset & ~left_empty & ~right_empty
                        & lpr_ready_s & lmr_ready_s;
   assign left_rd_en  = pop_s;
   assign right_rd_en = pop_s;

   stream_hold_reg u_lpr_hold (
      .clock     (clock),
      .reset     (reset),
      .load      (pop_s),
      .load_data (lpr_val_s),
      .full      (lpr_full),
      .wr_en     (lpr_wr_en),
      .dout      (lpr_din),
      .ready     (lpr_ready_s)
   );

   stream_hold_reg u_lmr_hold (
      .clock     (clock),
      .reset     (reset),
      .load      (pop_s),
      .load_data (lmr_val_s),
      .full      (lmr_full),
      .wr_en     (lmr_wr_en),
      .dout      (lmr_din),
      .ready     (lmr_ready_s)
   );

endmodule
